// File: rtl/ntcrack_pkg.sv
// rtl/ntcrack_pkg.sv - shared command codes, timing default and state types for the NT cracker loader
package ntcrack_pkg;

   localparam int         DEFAULT_CLKS_PER_BIT = 538;
   localparam logic [7:0] CMD_HASH             = 8'h48;
   localparam logic [7:0] CMD_GO               = 8'h47;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic {
      P_CMD,
      P_HASH
   } parse_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer, start-bit glitch rejection and stop-bit check
module uart_rx
   import ntcrack_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int             CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic      sync1, sync2, rx_prev;
   rx_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, sh_n;
   logic          valid_n, ferr_n;

   // Idle-high reset values so release never looks like a falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_serial;
         sync2   <= sync1;
         rx_prev <= sync2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      sh_n    = shreg;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rx_prev && !sync2) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         RX_START: begin
            if (cnt == HALF) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = sync2 ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == FULL) begin
               cnt_n = '0;
               sh_n  = {sync2, shreg[7:1]};
               bit_n = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_n = RX_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == FULL) begin
               cnt_n   = '0;
               state_n = RX_IDLE;
               valid_n = sync2;
               ferr_n  = !sync2;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         bit_idx  <= bit_n;
         shreg    <= sh_n;
         rx_valid <= valid_n;
         rx_ferr  <= ferr_n;
      end
   end

   assign rx_byte = shreg;

endmodule

// File: rtl/hash_uart_loader.sv
// rtl/hash_uart_loader.sv - UART command parser loading NT hashes into the cracker and issuing go
module hash_uart_loader
   import ntcrack_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int HASH_BYTES   = 16,
   parameter int MAX_HASHES   = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   output logic [7:0] new_hash_byte,
   output logic       store_hash_byte,
   output logic       go,
   output logic       busy,
   output logic       frame_error,
   output logic [7:0] hash_count
);

   localparam int             IW      = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
   localparam logic [IW-1:0] LAST    = IW'(HASH_BYTES - 1);
   localparam logic [7:0]    MAX_CNT = 8'(MAX_HASHES);

   logic [7:0]   rx_byte;
   logic         rx_valid, rx_ferr;
   parse_state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic          sat, sat_n;
   logic [7:0]    byte_n, count_n;
   logic          store_n, go_n, ferr_n;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_ferr   (rx_ferr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= P_CMD;
      else     state <= state_n;
   end

   // A frame that starts while the table is full still swallows its bytes, silently
   always_comb begin
      state_n = state;
      idx_n   = idx;
      sat_n   = sat;
      byte_n  = new_hash_byte;
      store_n = 1'b0;
      go_n    = 1'b0;
      ferr_n  = frame_error;
      count_n = hash_count;
      if (rx_ferr) begin
         ferr_n  = 1'b1;
         state_n = P_CMD;
      end else if (rx_valid) begin
         case (state)
            P_CMD: begin
               if (rx_byte == CMD_HASH) begin
                  state_n = P_HASH;
                  idx_n   = '0;
                  sat_n   = (hash_count == MAX_CNT);
               end else if (rx_byte == CMD_GO && hash_count != 8'd0) begin
                  go_n = 1'b1;
               end
            end
            P_HASH: begin
               if (!sat) begin
                  byte_n  = rx_byte;
                  store_n = 1'b1;
               end
               idx_n = idx + 1'b1;
               if (idx == LAST) begin
                  state_n = P_CMD;
                  if (!sat) count_n = hash_count + 8'd1;
               end
            end
            default: state_n = P_CMD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx             <= '0;
         sat             <= 1'b0;
         new_hash_byte   <= 8'd0;
         store_hash_byte <= 1'b0;
         go              <= 1'b0;
         frame_error     <= 1'b0;
         hash_count      <= 8'd0;
      end else begin
         idx             <= idx_n;
         sat             <= sat_n;
         new_hash_byte   <= byte_n;
         store_hash_byte <= store_n;
         go              <= go_n;
         frame_error     <= ferr_n;
         hash_count      <= count_n;
      end
   end

   assign busy = (state == P_HASH);

endmodule

// File: tb/tb_hash_uart_loader.sv
// tb/tb_hash_uart_loader.sv - randomized self-checking bench for hash_uart_loader with byte-level model
module tb_hash_uart_loader;

   localparam int CLKS = 16;
   localparam int HB   = 16;
   localparam int MAXH = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_serial;
   logic [7:0] new_hash_byte;
   logic       store_hash_byte;
   logic       go;
   logic       busy;
   logic       frame_error;
   logic [7:0] hash_count;

   hash_uart_loader #(.CLKS_PER_BIT(CLKS), .HASH_BYTES(HB), .MAX_HASHES(MAXH)) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_serial       (rx_serial),
      .new_hash_byte   (new_hash_byte),
      .store_hash_byte (store_hash_byte),
      .go              (go),
      .busy            (busy),
      .frame_error     (frame_error),
      .hash_count      (hash_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte-level reference: what the loader should do with each received character
   int         m_count, m_idx, exp_go;
   bit         m_hash, m_sat, m_ferr;
   logic [7:0] exp_q[$];

   task automatic model_reset();
      m_count = 0; m_idx = 0; exp_go = 0;
      m_hash = 0; m_sat = 0; m_ferr = 0;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      if (!good) begin
         m_ferr = 1;
         m_hash = 0;
      end else if (!m_hash) begin
         if (b == 8'h48) begin
            m_hash = 1; m_idx = 0; m_sat = (m_count == MAXH);
         end else if (b == 8'h47 && m_count > 0) begin
            exp_go++;
         end
      end else begin
         if (!m_sat) exp_q.push_back(b);
         m_idx++;
         if (m_idx == HB) begin
            m_hash = 0;
            if (!m_sat) m_count++;
         end
      end
   endtask

   // Monitor
   logic [7:0] got_q[$];
   int         go_seen, both_seen, hold_err;
   logic [7:0] last_byte;

   always @(negedge clk) begin
      if (rst) begin
         last_byte = 8'd0;
      end else begin
         if (store_hash_byte) begin
            got_q.push_back(new_hash_byte);
            last_byte = new_hash_byte;
         end else if (new_hash_byte !== last_byte) begin
            hold_err++;
         end
         if (go) go_seen++;
         if (store_hash_byte && go) both_seen++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit good);
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         repeat (CLKS) @(negedge clk);
      end
      rx_serial = good;
      repeat (CLKS) @(negedge clk);
      rx_serial = 1'b1;
      repeat (CLKS) @(negedge clk);
      model_byte(b, good);
   endtask

   task automatic glitch();
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (3) @(negedge clk);
      rx_serial = 1'b1;
      repeat (3 * CLKS) @(negedge clk);
   endtask

   task automatic flush(input string tag);
      int n;
      check($sformatf("%s_nstrobes", tag), 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(hash_count), 32'(m_count));
      check({tag, "_busy"},  32'(busy),       32'(m_hash));
      check({tag, "_ferr"},  32'(frame_error), 32'(m_ferr));
      check({tag, "_go"},    32'(go_seen),    32'(exp_go));
   endtask

   task automatic send_hash(input bit seq);
      send_byte(8'h48, 1'b1);
      for (int i = 0; i < HB; i++)
         send_byte(seq ? 8'(i) : 8'($urandom_range(0, 255)), 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      go_seen = 0; both_seen = 0; hold_err = 0;
      model_reset();
      rst = 1'b1;
      rx_serial = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_byte",  32'(new_hash_byte),   32'd0);
      check("rst_store", 32'(store_hash_byte), 32'd0);
      check("rst_go",    32'(go),              32'd0);
      check_state("rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send_byte(8'h47, 1'b1);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h48 || b == 8'h47) b = 8'h00;
         send_byte(b, 1'b1);
      end
      check_state("g_empty");

      send_hash(1'b1);
      flush("seq_hash");
      check_state("seq_hash");

      send_byte(8'h47, 1'b1);
      check_state("go1");

      send_byte(8'h48, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      flush("abort");
      check_state("abort");

      send_byte(8'h48, 1'b1);
      for (int i = 0; i < HB; i++) begin
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         if (i == 7) begin
            glitch();
            check("glitch_busy", 32'(busy), 32'd1);
         end
      end
      flush("glitch_hash");
      check_state("glitch_hash");

      while (m_count < MAXH) send_hash(1'b0);
      flush("fill");
      check_state("fill");
      send_hash(1'b0);
      flush("sat");
      check_state("sat");
      send_byte(8'h47, 1'b1);
      check_state("go2");

      send_byte(8'h48, 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      flush("pre_rst");
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (3 * CLKS) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mrst_byte",  32'(new_hash_byte),   32'd0);
      check("mrst_store", 32'(store_hash_byte), 32'd0);
      check("mrst_go",    32'(go),              32'd0);
      check("mrst_busy",  32'(busy),            32'd0);
      check("mrst_ferr",  32'(frame_error),     32'd0);
      check("mrst_count", 32'(hash_count),      32'd0);
      rx_serial = 1'b1;
      repeat (40) @(negedge clk);
      rst = 1'b0;
      model_reset();
      go_seen = 0;
      got_q.delete();
      repeat (4 * CLKS) @(negedge clk);
      send_byte(8'h47, 1'b1);
      flush("post_rst");
      check_state("post_rst");

      check("store_go_overlap", 32'(both_seen), 32'd0);
      check("byte_hold",        32'(hold_err),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hash_uart_loader.md
HASH_UART_LOADER -- requirements
Module: hash_uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 538, clk cycles per UART bit (62 MHz / 115200 baud).
REQ-002 SHALL have parameter HASH_BYTES, default 16, bytes per NT hash.
REQ-003 SHALL have parameter MAX_HASHES, default 128, hash slots available in the cracker.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port rx_serial, input, 1 bit: asynchronous UART line, idle high.
REQ-007 SHALL have port new_hash_byte, output, 8 bits: hash byte presented to the cracker.
REQ-008 SHALL have port store_hash_byte, output, 1 bit: one-cycle strobe qualifying new_hash_byte.
REQ-009 SHALL have port go, output, 1 bit: one-cycle start strobe to the cracker.
REQ-010 SHALL have port busy, output, 1 bit: high while a hash frame is in progress.
REQ-011 SHALL have port frame_error, output, 1 bit: sticky flag for a bad stop bit.
REQ-012 SHALL have port hash_count, output, 8 bits: number of complete hashes delivered.

Function
REQ-013 SHALL pass rx_serial through a 2-flop synchronizer before any use.
REQ-014 SHALL detect a start bit on a synchronized high-to-low transition while the receiver is idle.
REQ-015 SHALL re-sample the start bit at CLKS_PER_BIT/2 and return to idle without output if it reads high (glitch).
REQ-016 SHALL sample 8 data bits LSB-first at bit centres, then the stop bit.
REQ-017 SHALL deliver a received byte as a one-cycle rx_valid internally, 1 cycle after the stop-bit sample reads high.
REQ-018 SHALL, on a stop bit reading 0, discard the byte, set frame_error, and abort any hash frame in progress to CMD.
REQ-019 SHALL implement the parser states CMD and HASH.
REQ-020 In CMD, byte 0x48 ('H') SHALL enter HASH with the byte index cleared and busy set.
REQ-021 In CMD, byte 0x47 ('G') SHALL pulse go for exactly 1 cycle if hash_count > 0, else be ignored.
REQ-022 In CMD, any other byte SHALL be ignored.
REQ-023 In HASH, each byte SHALL drive new_hash_byte and pulse store_hash_byte in the cycle after rx_valid.
REQ-024 new_hash_byte SHALL hold its value until the next strobe.
REQ-025 After the HASH_BYTES-th byte, the parser SHALL increment hash_count, clear busy and return to CMD in the same cycle as the final strobe.
REQ-026 If hash_count == MAX_HASHES when 'H' arrives, HASH SHALL still consume HASH_BYTES bytes, but SHALL issue no strobes and SHALL not increment hash_count (saturate).
REQ-027 On abort, bytes already strobed SHALL stay strobed, and hash_count SHALL be unchanged.
REQ-028 store_hash_byte and go SHALL never be high in the same cycle.

Reset
REQ-029 rst SHALL asynchronously force CMD state, receiver idle, new_hash_byte=0, store_hash_byte=0, go=0, busy=0, frame_error=0, hash_count=0.
REQ-030 Synchronizer flops SHALL reset to 1.
REQ-031 A byte partially received when rst asserts SHALL be lost, with no strobe after release.

Structure
REQ-032 Command codes 0x48/0x47 and the default CLKS_PER_BIT SHALL live in the shared package ntcrack_pkg.
REQ-033 The bit-level receiver SHALL be the sub-module uart_rx (clk, rst, rx_serial -> rx_byte, rx_valid, rx_ferr); parsing stays in hash_uart_loader.

Verification (CLKS_PER_BIT=16 in bench)
REQ-034 'H' then bytes 0x00..0x0F -> 16 strobes with new_hash_byte 0x00..0x0F in order; hash_count=1; busy low after the 16th strobe.
REQ-035 'G' with hash_count=0 -> no go; after one full hash, 'G' -> go high exactly 1 cycle.
REQ-036 Stop bit 0 on the 5th hash byte -> 4 strobes only; frame_error=1; hash_count unchanged; next 'H' is accepted.
REQ-037 128 full hashes, then 'H' plus 16 bytes -> no strobes; hash_count stays 128 (0x80).
REQ-038 Low glitch of 3 cycles on rx_serial -> no byte; parser unaffected.
REQ-039 rst asserted mid-byte during HASH -> all outputs 0 immediately; a subsequent 'G' is ignored.
